// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 responder for a fixed-width frame link.
// Oversamples cs_n/sclk/mosi in the i_clock domain, shifts MOSI into an RX
// register on SCLK rises, shifts a preloaded TX word out on MISO on SCLK
// falls, and closes the frame on the cs_n rise with either a one-cycle
// o_rx_valid strobe (exact bit count) or a one-cycle o_frame_error strobe.
// Optional build macro: SPI_PERIPHERAL_LOOPBACK_EN -- when defined, the TX
// register loads the last good received word at frame start instead of
// i_tx_data (link bring-up without host logic).
module spi_peripheral #(
  parameter int SPI_DATA_WIDTH = 32,
  parameter int SYNC_STAGES    = 2   // must be 2 or more
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_spi_cs_n,
  input  logic                      i_spi_clock,
  input  logic                      i_spi_mosi,
  output logic                      o_spi_miso,
  input  logic [SPI_DATA_WIDTH-1:0] i_tx_data,
  output logic                      o_tx_load,
  output logic [SPI_DATA_WIDTH-1:0] o_rx_data,
  output logic                      o_rx_valid,
  output logic                      o_frame_error
);

  // Counter must reach SPI_DATA_WIDTH+1 so over-long frames stay distinguishable.
  localparam int                CNT_W    = $clog2(SPI_DATA_WIDTH + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(SPI_DATA_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(SPI_DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  // Synchronizer chains; reset to 0 so a cs_n held low through reset release
  // never looks like a fresh frame start.
  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic                   cs_dly_reg;
  logic                   sclk_dly_reg;

  logic cs_last;
  logic sclk_last;
  logic mosi_last;
  logic cs_rise;
  logic cs_fall;
  logic sclk_rise;
  logic sclk_fall;

  state_t                    state_reg,       state_next;
  logic [SPI_DATA_WIDTH-1:0] rx_shift_reg,    rx_shift_next;
  logic [SPI_DATA_WIDTH-1:0] tx_shift_reg,    tx_shift_next;
  logic [CNT_W-1:0]          bit_cnt_reg,     bit_cnt_next;
  logic [SPI_DATA_WIDTH-1:0] rx_data_reg,     rx_data_next;
  logic                      rx_valid_reg,    rx_valid_next;
  logic                      frame_error_reg, frame_error_next;
  logic                      tx_load_reg,     tx_load_next;
  logic [SPI_DATA_WIDTH-1:0] load_word;

  // Pin synchronizers plus one-cycle delayed copies for edge detection.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cs_sync_reg   <= '0;
      sclk_sync_reg <= '0;
      mosi_sync_reg <= '0;
      cs_dly_reg    <= 1'b0;
      sclk_dly_reg  <= 1'b0;
    end else begin
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0],   i_spi_cs_n};
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], i_spi_clock};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], i_spi_mosi};
      cs_dly_reg    <= cs_sync_reg[SYNC_STAGES-1];
      sclk_dly_reg  <= sclk_sync_reg[SYNC_STAGES-1];
    end
  end

  assign cs_last   = cs_sync_reg[SYNC_STAGES-1];
  assign sclk_last = sclk_sync_reg[SYNC_STAGES-1];
  assign mosi_last = mosi_sync_reg[SYNC_STAGES-1];
  assign cs_rise   =  cs_last   & ~cs_dly_reg;
  assign cs_fall   = ~cs_last   &  cs_dly_reg;
  assign sclk_rise =  sclk_last & ~sclk_dly_reg;
  assign sclk_fall = ~sclk_last &  sclk_dly_reg;

`ifdef SPI_PERIPHERAL_LOOPBACK_EN
  assign load_word = rx_data_reg;
`else
  assign load_word = i_tx_data;
`endif

  // FSM state, shift registers, counter and registered output strobes.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg       <= WAIT_IDLE;
      rx_shift_reg    <= '0;
      tx_shift_reg    <= '0;
      bit_cnt_reg     <= '0;
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      frame_error_reg <= 1'b0;
      tx_load_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rx_shift_reg    <= rx_shift_next;
      tx_shift_reg    <= tx_shift_next;
      bit_cnt_reg     <= bit_cnt_next;
      rx_data_reg     <= rx_data_next;
      rx_valid_reg    <= rx_valid_next;
      frame_error_reg <= frame_error_next;
      tx_load_reg     <= tx_load_next;
    end
  end

  // Next-state and datapath; an SCLK edge coinciding with the cs_n rise is
  // applied first so the close sees the final bit count and RX word.
  always_comb begin
    state_next       = state_reg;
    rx_shift_next    = rx_shift_reg;
    tx_shift_next    = tx_shift_reg;
    bit_cnt_next     = bit_cnt_reg;
    rx_data_next     = rx_data_reg;
    rx_valid_next    = 1'b0;
    frame_error_next = 1'b0;
    tx_load_next     = 1'b0;

    case (state_reg)
      WAIT_IDLE: begin
        if (cs_last) begin
          state_next = IDLE;
        end
      end

      IDLE: begin
        if (cs_fall) begin
          tx_shift_next = load_word;
          tx_load_next  = 1'b1;
          bit_cnt_next  = '0;
          state_next    = ACTIVE;
        end
      end

      ACTIVE: begin
        if (sclk_rise) begin
          rx_shift_next = {rx_shift_reg[SPI_DATA_WIDTH-2:0], mosi_last};
          if (bit_cnt_reg != CNT_SAT) begin
            bit_cnt_next = bit_cnt_reg + CNT_ONE;
          end
        end
        if (sclk_fall) begin
          tx_shift_next = {tx_shift_reg[SPI_DATA_WIDTH-2:0], 1'b0};
        end
        if (cs_rise) begin
          if (bit_cnt_next == CNT_FULL) begin
            rx_data_next  = rx_shift_next;
            rx_valid_next = 1'b1;
          end else begin
            frame_error_next = 1'b1;
          end
          state_next = IDLE;
        end
      end

      default: begin
        state_next = WAIT_IDLE;
      end
    endcase
  end

  assign o_spi_miso    = (state_reg == ACTIVE) ? tx_shift_reg[SPI_DATA_WIDTH-1] : 1'b0;
  assign o_tx_load     = tx_load_reg;
  assign o_rx_data     = rx_data_reg;
  assign o_rx_valid    = rx_valid_reg;
  assign o_frame_error = frame_error_reg;

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed SPI frames against spi_peripheral. The driver
// pushes the expected frame-close event (valid or error, word, cycle) into a
// queue at each cs_n rise; a monitor pops and compares on every strobe.
// Build with SPI_PERIPHERAL_LOOPBACK_EN to check the loopback MISO source.
module tb_spi_peripheral;

  localparam int W    = 32;
  localparam int SS   = 2;
  localparam int HALF = 6;       // SCLK half period in clk cycles (>= SS+2)
  localparam int LEAD = 8;       // cs_n fall to first MOSI setup
  localparam int GAP  = SS + 2;  // minimum cs_n high time

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         cs_n  = 1'b0;
  logic         sclk  = 1'b0;
  logic         mosi  = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         miso;
  logic         tx_load;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         frame_error;

  always #5 clk = ~clk;

  spi_peripheral #(
    .SPI_DATA_WIDTH(W),
    .SYNC_STAGES   (SS)
  ) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_spi_cs_n   (cs_n),
    .i_spi_clock  (sclk),
    .i_spi_mosi   (mosi),
    .o_spi_miso   (miso),
    .i_tx_data    (tx_data),
    .o_tx_load    (tx_load),
    .o_rx_data    (rx_data),
    .o_rx_valid   (rx_valid),
    .o_frame_error(frame_error)
  );

  typedef struct {
    bit           is_err;
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           tests_run    = 0;
  int           tests_failed = 0;
  int           cyc          = 0;
  int           tx_load_cnt  = 0;
  logic [W-1:0] last_good    = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every close strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (tx_load) tx_load_cnt++;
    if (rx_valid || frame_error) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 64'({rx_valid, frame_error}), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_kind", 64'({rx_valid, frame_error}), mon_e.is_err ? 64'(1) : 64'(2));
        check("rx_data", 64'(rx_data), 64'(mon_e.data));
        check("close_latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clock out bits[hi..lo] MSB first; MISO captured at each SCLK rise.
  task automatic shift_bits(input int hi, input int lo, input logic [63:0] bits,
                            inout logic [W-1:0] mw);
    for (int i = hi; i >= lo; i--) begin
      mosi = bits[i];
      tick(HALF);
      sclk = 1'b1;
      mw   = {mw[W-2:0], miso};
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  // Full frame of nbits; queues the expected close and checks MISO/tx_load.
  task automatic send_frame(input int nbits, input logic [63:0] bits, input logic [W-1:0] txw);
    logic [W-1:0] exp_tx;
    logic [W-1:0] mw;
    exp_t         e;
    int           loads0;
    tx_data = txw;
    loads0  = tx_load_cnt;
    mw      = '0;
`ifdef SPI_PERIPHERAL_LOOPBACK_EN
    exp_tx = last_good;
`else
    exp_tx = txw;
`endif
    cs_n = 1'b0;
    tick(LEAD);
    shift_bits(nbits - 1, 0, bits, mw);
    tick(HALF);
    e.is_err = (nbits != W);
    e.data   = (nbits == W) ? bits[W-1:0] : last_good;
    e.cyc    = cyc + 1 + SS;
    exp_q.push_back(e);
    if (nbits == W) last_good = bits[W-1:0];
    cs_n = 1'b1;
    tick(GAP);
    check("tx_load_count", 64'(tx_load_cnt - loads0), 64'(1));
    if (nbits == W) check("miso_word", 64'(mw), 64'(exp_tx));
    $display("[TB] frame %0d bits mosi=0x%0h tx=0x%0h miso=0x%0h", nbits, bits, txw, mw);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] mw;

    // Reset held with cs_n already low; a frame runs through the release.
    #2 rst_n = 1'b0;
    tick(4);
    check("reset_rx_data",  64'(rx_data),     64'(0));
    check("reset_miso",     64'(miso),        64'(0));
    check("reset_strobes",  64'({rx_valid, frame_error, tx_load}), 64'(0));
    rst_n = 1'b1;
    mw = '0;
    shift_bits(31, 0, 64'hFFFF_0000_AAAA_5555, mw);
    tick(HALF);
    cs_n = 1'b1;
    tick(GAP + 4);
    check("discard_no_load", 64'(tx_load_cnt), 64'(0));
    check("discard_rx_data", 64'(rx_data),     64'(0));
    $display("[TB] frame in progress at reset release discarded");

    // Normal frame, then short and long frames.
    send_frame(32, 64'hA5C3_1E0F, 32'h1234_5678);
    send_frame(31, 64'h5555_5555, 32'h0BAD_0BAD);
    check("hold_after_short", 64'(rx_data), 64'hA5C3_1E0F);
    send_frame(33, 64'h1_FFFF_0000, 32'h0BAD_0BAD);
    check("hold_after_long", 64'(rx_data), 64'hA5C3_1E0F);

    // Back-to-back frames with the minimum cs_n high gap.
    send_frame(32, 64'hFFFF_FFFF, 32'h8000_0001);
    send_frame(32, 64'h0000_0001, 32'hFFFF_FFFE);

    // Reset after 16 bits, released with cs_n still low.
    mw = '0;
    tx_data = 32'h7777_7777;
    cs_n = 1'b0;
    tick(LEAD);
    shift_bits(31, 16, 64'hC0DE_F00D, mw);
    rst_n = 1'b0;
    tick(3);
    check("midreset_rx_data", 64'(rx_data), 64'(0));
    check("midreset_miso",    64'(miso),    64'(0));
    rst_n = 1'b1;
    last_good = '0;
    mw = '0;
    shift_bits(15, 0, 64'hC0DE_F00D, mw);
    check("post_reset_miso", 64'(mw[15:0]), 64'(0));
    tick(HALF);
    cs_n = 1'b1;
    tick(GAP + 4);
    check("post_reset_rx_data", 64'(rx_data), 64'(0));
    $display("[TB] frame interrupted by reset at bit 16");

    send_frame(32, 64'h0F0F_5A5A, 32'hCAFE_F00D);

    // Loopback check pair (normal MISO when the macro is off).
    send_frame(32, 64'hDEAD_BEEF, 32'h0000_FFFF);
    send_frame(32, 64'h1357_9BDF, 32'h2468_ACE0);

    tick(10);
    check("pending_events", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
